// File: rtl/if_fetch_stage_pkg.sv
// if_fetch_stage_pkg: fetch widths, default reset PC and the buffer entry layout
package if_fetch_stage_pkg;
  localparam int PC_W = 32;
  localparam int INST_W = 32;
  localparam logic [PC_W-1:0] DEF_RESET_PC = 32'h1c00_0000;
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              adef;
  } fetch_entry_t;
endpackage

// File: rtl/if_fetch_stage_fetch_buf.sv
// if_fetch_stage_fetch_buf: synchronous FIFO with flush; flush and push never coincide
module if_fetch_stage_fetch_buf #(
  parameter int W = 65,
  parameter int D = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 push,
  input  logic                 pop,
  input  logic [W-1:0]         din,
  output logic [W-1:0]         dout,
  output logic [$clog2(D):0]   count
);
  localparam int AW = $clog2(D);
  logic [W-1:0] mem [D];
  logic [AW-1:0] rd_ptr, wr_ptr;
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  assign dout = mem[rd_ptr];
endmodule

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: fetch PC, inst SRAM requests and the decode-facing instruction buffer.
// Define IF_ADEF_CHECK_EN to turn misaligned fetch addresses into fs_adef entries.
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = DEF_RESET_PC,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  output logic              inst_sram_en,
  output logic              inst_sram_we,
  output logic [PC_W-1:0]   inst_sram_addr,
  output logic [INST_W-1:0] inst_sram_wdata,
  input  logic [INST_W-1:0] inst_sram_rdata,
  output logic              fs_valid,
  input  logic              fs_ready,
  output logic [PC_W-1:0]   fs_pc,
  output logic [INST_W-1:0] fs_inst,
  output logic              fs_adef,
  input  logic              br_redirect,
  input  logic [PC_W-1:0]   br_target
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  logic [PC_W-1:0] req_pc, resp_pc, issue_addr;
  logic inflight, inflight_adef, halted, issue, adef_hit, pop, push;
  logic [CW-1:0] count;
  logic [CW:0] occ;
  fetch_entry_t head, wr_entry;
  assign fs_valid = count != '0;
  assign pop = fs_valid & fs_ready;
  // credits: buffered + in flight, minus what leaves this cycle
  always_comb begin
    issue_addr = br_redirect ? br_target : req_pc;
    occ = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    issue = ~reset & (br_redirect | (~halted & (occ < (CW+1)'(BUF_DEPTH))));
`ifdef IF_ADEF_CHECK_EN
    adef_hit = issue & (issue_addr[1:0] != 2'b00);
`else
    adef_hit = 1'b0;
`endif
    push = inflight & ~br_redirect;
    wr_entry = {resp_pc, inst_sram_rdata & {INST_W{~inflight_adef}}, inflight_adef};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      req_pc <= RESET_PC;
      resp_pc <= '0;
      inflight <= 1'b0;
      inflight_adef <= 1'b0;
      halted <= 1'b0;
    end else begin
      inflight <= issue;
      inflight_adef <= adef_hit;
      halted <= br_redirect ? adef_hit : (halted | adef_hit);
      if (issue) begin
        resp_pc <= issue_addr;
        req_pc <= issue_addr + 32'd4;
      end
    end
  end
  if_fetch_stage_fetch_buf #(.W($bits(fetch_entry_t)), .D(BUF_DEPTH)) u_buf (
    .clk(clk),
    .reset(reset),
    .flush(br_redirect),
    .push(push),
    .pop(pop),
    .din(wr_entry),
    .dout(head),
    .count(count)
  );
  assign inst_sram_en = issue & ~adef_hit;
  assign inst_sram_we = 1'b0;
  assign inst_sram_addr = issue_addr;
  assign inst_sram_wdata = '0;
  assign fs_pc = fs_valid ? head.pc : '0;
  assign fs_inst = fs_valid ? head.inst : '0;
  assign fs_adef = fs_valid & head.adef;
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed fetch scenarios plus an in-order {pc,inst} scoreboard
module tb_if_fetch_stage;
  localparam logic [31:0] RST = 32'h1c00_0000;
  logic clk = 1'b0, reset = 1'b1;
  logic inst_sram_en, inst_sram_we, fs_valid, fs_adef;
  logic fs_ready = 1'b0, br_redirect = 1'b0;
  logic [31:0] inst_sram_addr, inst_sram_wdata, fs_pc, fs_inst;
  logic [31:0] inst_sram_rdata = '0, br_target = '0;
  int n_chk = 0, n_pass = 0;
  typedef struct { logic [31:0] pc; logic [31:0] inst; logic adef; } exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  if_fetch_stage dut (
    .clk(clk), .reset(reset),
    .inst_sram_en(inst_sram_en), .inst_sram_we(inst_sram_we),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_rdata(inst_sram_rdata),
    .fs_valid(fs_valid), .fs_ready(fs_ready), .fs_pc(fs_pc), .fs_inst(fs_inst),
    .fs_adef(fs_adef), .br_redirect(br_redirect), .br_target(br_target)
  );
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]};
  endfunction
  always @(posedge clk) if (inst_sram_en) inst_sram_rdata <= inst_of(inst_sram_addr);
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", tag, act, exp);
  endtask
  task automatic go();
    @(posedge clk);
    #1;
  endtask
  task automatic rst_dut();
    reset = 1'b1;
    br_redirect = 1'b0;
    go();
    reset = 1'b0;
  endtask
  always @(negedge clk) begin
    if (reset) sb.delete();
    else begin
      if (fs_valid && fs_ready) begin
        if (sb.size() == 0) check("sb_spurious", 32'(sb.size()), 32'd1);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_pc", fs_pc, e.pc);
          check("sb_inst", fs_inst, e.inst);
          check("sb_adef", 32'(fs_adef), 32'(e.adef));
        end
      end
      if (br_redirect) sb.delete();
`ifdef IF_ADEF_CHECK_EN
      if (br_redirect && br_target[1:0] != 2'b00) sb.push_back('{br_target, 32'd0, 1'b1});
`endif
      if (inst_sram_en) sb.push_back('{inst_sram_addr, inst_of(inst_sram_addr), 1'b0});
    end
  end
  initial begin
    #200000;
    $display("FAIL timeout: got running, want finished");
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(fs_valid), 32'd0);
    check("rst_en", 32'(inst_sram_en), 32'd0);
    check("rst_pc", fs_pc, 32'd0);
    check("rst_inst", fs_inst, 32'd0);
    check("rst_adef", 32'(fs_adef), 32'd0);
    check("rst_we", 32'(inst_sram_we), 32'd0);
    check("rst_wdata", inst_sram_wdata, 32'd0);
    go();
    reset = 1'b0;
    fs_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t1_en", 32'(inst_sram_en), 32'd1);
      check("t1_addr", inst_sram_addr, RST + 32'(4 * i));
      check("t1_valid", 32'(fs_valid), 32'(i >= 2));
      if (i >= 2) check("t1_pc", fs_pc, RST + 32'(4 * (i - 2)));
      go();
    end
    fs_ready = 1'b1;
    rst_dut();
    repeat (4) go();
    fs_ready = 1'b0;
    @(negedge clk);
    check("t2_en_drop", 32'(inst_sram_en), 32'd0);
    go();
    @(negedge clk);
    check("t2_en_full", 32'(inst_sram_en), 32'd0);
    check("t2_head", fs_pc, RST + 32'h8);
    go();
    fs_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t2_valid", 32'(fs_valid), 32'd1);
      check("t2_pc", fs_pc, RST + 32'h8 + 32'(4 * i));
      go();
    end
    fs_ready = 1'b0;
    rst_dut();
    go();
    go();
    br_redirect = 1'b1;
    br_target = RST + 32'h100;
    @(negedge clk);
    check("t3_en", 32'(inst_sram_en), 32'd1);
    check("t3_addr", inst_sram_addr, RST + 32'h100);
    go();
    br_redirect = 1'b0;
    fs_ready = 1'b1;
    @(negedge clk);
    check("t3_valid", 32'(fs_valid), 32'd0);
    check("t3_addr2", inst_sram_addr, RST + 32'h104);
    go();
    @(negedge clk);
    check("t3_pc0", fs_pc, RST + 32'h100);
    go();
    @(negedge clk);
    check("t3_pc1", fs_pc, RST + 32'h104);
    go();
    rst_dut();
    go();
    go();
    br_redirect = 1'b1;
    br_target = RST + 32'h200;
    @(negedge clk);
    check("t4_popped", fs_pc, RST);
    go();
    br_redirect = 1'b0;
    @(negedge clk);
    check("t4_valid", 32'(fs_valid), 32'd0);
    go();
    @(negedge clk);
    check("t4_pc0", fs_pc, RST + 32'h200);
    go();
    @(negedge clk);
    check("t4_pc1", fs_pc, RST + 32'h204);
    go();
    br_redirect = 1'b1;
    br_target = 32'hFFFF_FFFC;
    @(negedge clk);
    check("t5_addr", inst_sram_addr, 32'hFFFF_FFFC);
    go();
    br_redirect = 1'b0;
    @(negedge clk);
    check("t5_wrap", inst_sram_addr, 32'h0);
    go();
    @(negedge clk);
    check("t5_pc_top", fs_pc, 32'hFFFF_FFFC);
    go();
    @(negedge clk);
    check("t5_pc_zero", fs_pc, 32'h0);
    go();
    reset = 1'b1;
    go();
    reset = 1'b0;
    @(negedge clk);
    check("t5_rst_valid", 32'(fs_valid), 32'd0);
    check("t5_rst_addr", inst_sram_addr, RST);
    go();
    go();
    @(negedge clk);
    check("t5_rst_pc", fs_pc, RST);
    go();
`ifdef IF_ADEF_CHECK_EN
    rst_dut();
    go();
    go();
    br_redirect = 1'b1;
    br_target = RST + 32'h102;
    @(negedge clk);
    check("t6_en", 32'(inst_sram_en), 32'd0);
    go();
    br_redirect = 1'b0;
    @(negedge clk);
    check("t6_halt", 32'(inst_sram_en), 32'd0);
    check("t6_empty", 32'(fs_valid), 32'd0);
    go();
    @(negedge clk);
    check("t6_adef", 32'(fs_adef), 32'd1);
    check("t6_pc", fs_pc, RST + 32'h102);
    check("t6_inst", fs_inst, 32'd0);
    check("t6_halt2", 32'(inst_sram_en), 32'd0);
    go();
    br_redirect = 1'b1;
    br_target = RST + 32'h200;
    @(negedge clk);
    check("t6_resume_en", 32'(inst_sram_en), 32'd1);
    check("t6_resume_addr", inst_sram_addr, RST + 32'h200);
    go();
    br_redirect = 1'b0;
    go();
    @(negedge clk);
    check("t6_resume_pc", fs_pc, RST + 32'h200);
    check("t6_resume_adef", 32'(fs_adef), 32'd0);
    go();
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
